// File: rtl/shift_div16.sv
// Bit-serial restoring divider: 16-bit unsigned dividend by B_WIDTH-bit divisor,
// one quotient bit per falling clock edge, MSB first.
module shift_div16 #(
  parameter int unsigned B_WIDTH = 8
) (
  input  logic               clk,
  input  logic               div_rst_n,
  input  logic               start,
  input  logic [15:0]        a,
  input  logic [B_WIDTH-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [15:0]        y,
  output logic [B_WIDTH-1:0] rem,
  output logic               dbz
);

  localparam int unsigned PR_W = B_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [15:0]        r_dvd, w_dvd_nxt;
  logic [B_WIDTH-1:0] r_dvs, w_dvs_nxt;
  logic [PR_W-1:0]    r_pr, w_pr_nxt;
  logic [15:0]        r_quo, w_quo_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [15:0]        r_y, w_y_nxt;
  logic [B_WIDTH-1:0] r_rem, w_rem_nxt;
  logic               r_dbz, w_dbz_nxt;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  logic [PR_W-1:0] w_t;
  logic            w_ge;
  logic [PR_W-1:0] w_pr_step;
  logic [15:0]     w_quo_step;

  assign w_t        = {B_WIDTH'(r_pr), r_dvd[15]};
  assign w_ge       = (w_t >= {1'b0, r_dvs});
  assign w_pr_step  = w_ge ? (w_t - {1'b0, r_dvs}) : w_t;
  assign w_quo_step = (r_quo << 1) | 16'(w_ge);

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_dvd_nxt   = r_dvd;
    w_dvs_nxt   = r_dvs;
    w_pr_nxt    = r_pr;
    w_quo_nxt   = r_quo;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_y_nxt     = r_y;
    w_rem_nxt   = r_rem;
    w_dbz_nxt   = r_dbz;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_dvd_nxt   = a;
          w_dvs_nxt   = b;
          w_pr_nxt    = '0;
          w_quo_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        w_pr_nxt  = w_pr_step;
        w_dvd_nxt = r_dvd << 1;
        w_quo_nxt = w_quo_step;
        if (r_cnt == 4'd15) begin
          w_state_nxt = S_DONE;
          w_y_nxt     = w_quo_step;
          w_rem_nxt   = B_WIDTH'(w_pr_step);
          w_dbz_nxt   = (r_dvs == '0);
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Falling-edge state register, shared timing domain with the multiplier.
  always_ff @(negedge clk or negedge div_rst_n) begin
    if (!div_rst_n) begin
      r_state <= S_IDLE;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_pr    <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_y     <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dvd   <= w_dvd_nxt;
      r_dvs   <= w_dvs_nxt;
      r_pr    <= w_pr_nxt;
      r_quo   <= w_quo_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_y     <= w_y_nxt;
      r_rem   <= w_rem_nxt;
      r_dbz   <= w_dbz_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign y    = r_y;
  assign rem  = r_rem;
  assign dbz  = r_dbz;

endmodule

// File: tb/tb_shift_div16.sv
// Self-checking bench for shift_div16 (B_WIDTH=8) against an arithmetic reference.
module tb_shift_div16;

  localparam int unsigned BW = 8;

  logic          clk;
  logic          div_rst_n;
  logic          start;
  logic [15:0]   a;
  logic [BW-1:0] b;
  logic          busy;
  logic          done;
  logic [15:0]   y;
  logic [BW-1:0] rem;
  logic          dbz;

  int n_checks = 0;
  int n_fail   = 0;

  shift_div16 #(.B_WIDTH(BW)) dut (
    .clk(clk), .div_rst_n(div_rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .y(y), .rem(rem), .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer division, with the divide-by-zero result the algorithm yields.
  task automatic model(input logic [15:0] ma, input logic [BW-1:0] mb,
                       output logic [15:0] my, output logic [BW-1:0] mr, output logic md);
    if (mb == 0) begin
      my = 16'hFFFF;
      mr = ma[BW-1:0];
      md = 1'b1;
    end else begin
      my = ma / {8'd0, mb};
      mr = BW'(ma % {8'd0, mb});
      md = 1'b0;
    end
  endtask

  // Called just after a rising edge; start is seen at the following falling edge (E0).
  task automatic start_op(input logic [15:0] sa, input logic [BW-1:0] sb);
    a = sa;
    b = sb;
    start = 1'b1;
    @(negedge clk);
    @(posedge clk);
    start = 1'b0;
    a = 16'($urandom);
    b = BW'($urandom);
  endtask

  // Counts falling edges after E0 until done; also consumes the DONE edge (E17).
  task automatic wait_done(output int n, output bit held);
    logic [15:0]   y0;
    logic [BW-1:0] r0;
    logic          d0;
    bit            found;
    y0 = y; r0 = rem; d0 = dbz;
    held = 1'b1; found = 1'b0; n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      @(posedge clk);
      n = n + 1;
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
      if (y !== y0 || rem !== r0 || dbz !== d0) held = 1'b0;
    end
    if (!found) n = -1;
    else begin
      @(negedge clk);
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    div_rst_n = 1'b0;
    start = 1'b0;
    a = 16'hABCD;
    b = 8'h55;
    repeat (3) @(posedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (y !== 16'd0) begin n_fail++; $display("FAIL reset_y: got %h want 0", y); end
    n_checks++; if (rem !== 8'd0) begin n_fail++; $display("FAIL reset_rem: got %h want 0", rem); end
    n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", dbz); end
    div_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      n_checks++;
      if ({busy, done, y, rem, dbz} !== '0) begin
        n_fail++;
        $display("FAIL idle_hold cycle %0d: busy=%b done=%b y=%h rem=%h dbz=%b want all 0",
                 i, busy, done, y, rem, dbz);
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0]   va [6] = '{16'd1000, 16'd65535, 16'd5, 16'd40000, 16'h04D2, 16'd10};
    logic [BW-1:0] vb [6] = '{8'd7, 8'd255, 8'd9, 8'd1, 8'd0, 8'd3};
    logic [15:0]   ey [6] = '{16'd142, 16'd257, 16'd0, 16'd40000, 16'hFFFF, 16'd3};
    logic [BW-1:0] er [6] = '{8'd6, 8'd0, 8'd5, 8'd0, 8'hD2, 8'd1};
    logic          ed [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int n;
    bit held;
    for (int i = 0; i < 6; i++) begin
      start_op(va[i], vb[i]);
      wait_done(n, held);
      n_checks++; if (n != 16) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want 16", i, n); end
      n_checks++; if (!held) begin n_fail++; $display("FAIL dir%0d_hold: outputs changed during RUN", i); end
      n_checks++; if (y !== ey[i]) begin n_fail++; $display("FAIL dir%0d_y: got %0d want %0d", i, y, ey[i]); end
      n_checks++; if (rem !== er[i]) begin n_fail++; $display("FAIL dir%0d_rem: got %0d want %0d", i, rem, er[i]); end
      n_checks++; if (dbz !== ed[i]) begin n_fail++; $display("FAIL dir%0d_dbz: got %b want %b", i, dbz, ed[i]); end
    end
  endtask

  task automatic test_random();
    logic [15:0]   ra, my;
    logic [BW-1:0] rb, mr;
    logic          md;
    int n;
    bit held;
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : BW'($urandom);
      if (i == 0) rb = 8'd1;
      model(ra, rb, my, mr, md);
      start_op(ra, rb);
      wait_done(n, held);
      n_checks++;
      if (n != 16 || !held || y !== my || rem !== mr || dbz !== md) begin
        n_fail++;
        $display("FAIL rand%0d a=%0d b=%0d: got n=%0d held=%b y=%0d rem=%0d dbz=%b want n=16 held=1 y=%0d rem=%0d dbz=%b",
                 i, ra, rb, n, held, y, rem, dbz, my, mr, md);
      end
    end
  endtask

  task automatic test_handshake();
    int dones = 0;
    int n;
    bit held;
    start_op(16'd1000, 8'd7);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hs_busy_e0: got %b want 1", busy); end
    for (int e = 1; e <= 17; e++) begin
      start = (e == 5 || e == 17);
      a = 16'd9; b = 8'd2;
      @(negedge clk);
      @(posedge clk);
      start = 1'b0;
      if (done === 1'b1) dones++;
      n_checks++;
      if (e <= 16 && busy !== 1'b1) begin n_fail++; $display("FAIL hs_busy_e%0d: got %b want 1", e, busy); end
      else if (e == 17 && busy !== 1'b0) begin n_fail++; $display("FAIL hs_busy_e17: got %b want 0", busy); end
      if (e == 16) begin
        n_checks++;
        if (y !== 16'd142 || rem !== 8'd6) begin
          n_fail++; $display("FAIL hs_result1: got y=%0d rem=%0d want 142 6", y, rem);
        end
      end
    end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL hs_done_count: got %0d want 1", dones); end
    start_op(16'd65535, 8'd255);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hs_e18_accept: busy got %b want 1", busy); end
    wait_done(n, held);
    n_checks++;
    if (n != 16 || !held || y !== 16'd257 || rem !== 8'd0 || dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_result2: got n=%0d held=%b y=%0d rem=%0d dbz=%b want 16 1 257 0 0", n, held, y, rem, dbz);
    end
  endtask

  task automatic test_midreset();
    int n;
    bit held;
    bit saw_done = 1'b0;
    start_op(16'd1234, 8'd5);
    repeat (7) begin
      @(negedge clk);
      @(posedge clk);
    end
    div_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, y, rem, dbz} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: busy=%b done=%b y=%h rem=%h dbz=%b want all 0", busy, done, y, rem, dbz);
    end
    repeat (3) @(posedge clk);
    div_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL midrst_no_done: got activity want none"); end
    start_op(16'd300, 8'd17);
    wait_done(n, held);
    n_checks++;
    if (n != 16 || y !== 16'd17 || rem !== 8'd11 || dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_result: got n=%0d y=%0d rem=%0d dbz=%b want 16 17 11 0", n, y, rem, dbz);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_handshake();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
